// File: rtl/comms_pkg.sv
// Shared types and helpers for the UART transmit arbitration blocks.
// The state enum and the minimum-one-bit width helper are defined here.
package comms_pkg;

  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    CONCEDIDO = 2'd1,
    FINALIZA  = 2'd2
  } estado_t;

  // clog2 that never returns zero, so a 2-entry index still gets one bit
  function automatic int largura(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_seletor.sv
// Combinational round-robin picker: the first set request searching upward
// from the source after the last granted one, wrapping around.
module rr_seletor
  import comms_pkg::*;
#(
  parameter int  NUM_FONTES = 4,
  localparam int IW         = largura(NUM_FONTES)
) (
  input  logic [NUM_FONTES-1:0] pedido,
  input  logic [IW-1:0]         ultimo,
  output logic                  valido,
  output logic [IW-1:0]         indice
);

  logic [IW-1:0] idx;

  // Walk the ring from farthest to nearest so the nearest hit is written last.
  always_comb begin
    valido = |pedido;
    indice = '0;
    idx    = '0;
    for (int k = NUM_FONTES; k >= 1; k--) begin
      idx = IW'((int'(ultimo) + k) % NUM_FONTES);
      if (pedido[idx]) indice = idx;
    end
  end

endmodule

// File: rtl/tx_event_arbiter.sv
// Grants one of several event senders exclusive use of a single UART
// transmitter, round-robin, with a grant-length watchdog.
module tx_event_arbiter
  import comms_pkg::*;
#(
  parameter int  NUM_FONTES     = 4,
  parameter int  TIMEOUT_CICLOS = 100000,
  localparam int IW             = largura(NUM_FONTES),
  localparam int WW             = largura(TIMEOUT_CICLOS + 1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_FONTES-1:0]   pedido,
  output logic [NUM_FONTES-1:0]   habilitar_envio,
  input  logic [NUM_FONTES-1:0]   fonte_iniciar_envio,
  input  logic [8*NUM_FONTES-1:0] fonte_dado_saida,
  input  logic [NUM_FONTES-1:0]   fonte_envio_concluido,
  input  logic                    uart_ocupado,
  output logic                    uart_iniciar_envio,
  output logic [7:0]              uart_dado,
  output logic [IW-1:0]           fonte_atual,
  output logic                    ocupado,
  output logic                    erro_timeout
);

  localparam logic [WW-1:0] WD_LIMITE = WW'(TIMEOUT_CICLOS - 1);

  estado_t       estado, proximo;
  logic [IW-1:0] ultimo;
  logic [IW-1:0] sel_indice;
  logic          sel_valido;
  logic [WW-1:0] watchdog;
  logic          concluiu, caiu, estourou;

  rr_seletor #(.NUM_FONTES(NUM_FONTES)) u_seletor (
    .pedido (pedido),
    .ultimo (ultimo),
    .valido (sel_valido),
    .indice (sel_indice)
  );

  assign concluiu = fonte_envio_concluido[fonte_atual];
  assign caiu     = ~pedido[fonte_atual];
  // Watchdog holds the count of grant cycles already completed.
  assign estourou = (watchdog == WD_LIMITE);
  assign ocupado  = (estado != OCIOSO);

  always_comb begin
    proximo            = estado;
    uart_iniciar_envio = 1'b0;
    uart_dado          = 8'h00;
    case (estado)
      OCIOSO:    if (sel_valido) proximo = CONCEDIDO;
      CONCEDIDO: if (concluiu || caiu || estourou) proximo = FINALIZA;
      FINALIZA:  if (!uart_ocupado) proximo = OCIOSO;
      default:   proximo = OCIOSO;
    endcase
    if (estado == CONCEDIDO) begin
      uart_iniciar_envio = fonte_iniciar_envio[fonte_atual];
      for (int i = 0; i < NUM_FONTES; i++) begin
        if (fonte_atual == IW'(i)) uart_dado = fonte_dado_saida[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado          <= OCIOSO;
      habilitar_envio <= '0;
      watchdog        <= '0;
      ultimo          <= IW'(NUM_FONTES - 1);
      fonte_atual     <= '0;
      erro_timeout    <= 1'b0;
    end else begin
      estado       <= proximo;
      // A conclusion or a dropped request on the same cycle suppresses the error.
      erro_timeout <= (estado == CONCEDIDO) && !concluiu && !caiu && estourou;
      case (estado)
        OCIOSO: begin
          if (sel_valido) begin
            habilitar_envio <= {{(NUM_FONTES-1){1'b0}}, 1'b1} << sel_indice;
            fonte_atual     <= sel_indice;
            watchdog        <= '0;
          end
        end
        CONCEDIDO: begin
          watchdog <= watchdog + 1'b1;
          if (proximo == FINALIZA) habilitar_envio <= '0;
        end
        FINALIZA: begin
          if (!uart_ocupado) ultimo <= fonte_atual;
        end
        default: habilitar_envio <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_event_arbiter.sv
// Directed and randomized bench for tx_event_arbiter against a cycle-level
// behavioural model of the grant / finish / idle protocol.
module tb_tx_event_arbiter;

  localparam int N   = 4;
  localparam int TMO = 16;

  logic           clock = 1'b0;
  logic           reset;
  logic [N-1:0]   pedido, fonte_iniciar_envio, fonte_envio_concluido;
  logic [8*N-1:0] fonte_dado_saida;
  logic           uart_ocupado;
  logic [N-1:0]   habilitar_envio;
  logic           uart_iniciar_envio;
  logic [7:0]     uart_dado;
  logic [1:0]     fonte_atual;
  logic           ocupado, erro_timeout;

  tx_event_arbiter #(.NUM_FONTES(N), .TIMEOUT_CICLOS(TMO)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .pedido                (pedido),
    .habilitar_envio       (habilitar_envio),
    .fonte_iniciar_envio   (fonte_iniciar_envio),
    .fonte_dado_saida      (fonte_dado_saida),
    .fonte_envio_concluido (fonte_envio_concluido),
    .uart_ocupado          (uart_ocupado),
    .uart_iniciar_envio    (uart_iniciar_envio),
    .uart_dado             (uart_dado),
    .fonte_atual           (fonte_atual),
    .ocupado               (ocupado),
    .erro_timeout          (erro_timeout)
  );

  always #5 clock = ~clock;

  // Reference model: phase 0 idle, 1 granted, 2 finishing.
  int   m_phase, m_g, m_ultimo, m_done;
  bit   m_err;
  int   n_checks = 0, n_fail = 0;
  int   cyc = 0, grant_edge = 0, err_edge = 0, err_seen = 0;
  int   grants[$];
  logic [7:0] sent[$];
  logic [N-1:0] prev_hab = '0;

  function automatic bit bitof(input logic [N-1:0] v, input int i);
    logic [N-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  function automatic logic [7:0] byteof(input int i);
    logic [8*N-1:0] t;
    t = fonte_dado_saida >> (8 * i);
    return t[7:0];
  endfunction

  function automatic int rr_pick(input logic [N-1:0] req, input int last);
    for (int k = 1; k <= N; k++)
      if (bitof(req, (last + k) % N)) return (last + k) % N;
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_g = 0; m_ultimo = N - 1; m_done = 0; m_err = 0;
  endtask

  task automatic model_step();
    int w;
    m_err = 0;
    case (m_phase)
      0: begin
        w = rr_pick(pedido, m_ultimo);
        if (w >= 0) begin m_g = w; m_phase = 1; m_done = 0; end
      end
      1: begin
        m_done++;
        if (bitof(fonte_envio_concluido, m_g) || !bitof(pedido, m_g)) m_phase = 2;
        else if (m_done == TMO) begin m_phase = 2; m_err = 1; end
      end
      default: if (!uart_ocupado) begin m_phase = 0; m_ultimo = m_g; end
    endcase
  endtask

  task automatic compare_outputs();
    logic [N-1:0] exp_hab;
    exp_hab = (m_phase == 1) ? (N'(1) << m_g) : '0;
    check("habilitar_envio", habilitar_envio, exp_hab);
    check("ocupado", ocupado, m_phase != 0);
    check("fonte_atual", fonte_atual, m_g);
    check("erro_timeout", erro_timeout, m_err);
    check("uart_iniciar_envio", uart_iniciar_envio,
          (m_phase == 1) ? bitof(fonte_iniciar_envio, m_g) : 1'b0);
    check("uart_dado", uart_dado, (m_phase == 1) ? byteof(m_g) : 8'h00);
  endtask

  // One clock: check at the falling edge, then advance the model past the rising edge.
  task automatic cycle();
    @(negedge clock); #1;
    compare_outputs();
    if (habilitar_envio != 0 && prev_hab == 0) begin
      grants.push_back(int'(fonte_atual));
      grant_edge = cyc;
    end
    if (erro_timeout === 1'b1) begin err_seen++; err_edge = cyc; end
    if (uart_iniciar_envio === 1'b1) sent.push_back(uart_dado);
    prev_hab = habilitar_envio;
    @(posedge clock); cyc++;
    model_step();
    #1;
  endtask

  task automatic clear_inputs();
    pedido = '0; fonte_iniciar_envio = '0; fonte_envio_concluido = '0;
    fonte_dado_saida = '0; uart_ocupado = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    @(posedge clock); #1;
    model_reset();
    prev_hab = '0;
    reset = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_hab"}, habilitar_envio, '0);
    check({tag, "_ocupado"}, ocupado, 1'b0);
    check({tag, "_fonte_atual"}, fonte_atual, 2'd0);
    check({tag, "_erro"}, erro_timeout, 1'b0);
    check({tag, "_iniciar"}, uart_iniciar_envio, 1'b0);
    check({tag, "_dado"}, uart_dado, 8'h00);
  endtask

  initial begin
    #500000;
    $display("FAIL sim_time_limit observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int guard, t_grant, was_g;
    logic [N-1:0] pend;

    clear_inputs();
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_reset_values("reset");
    reset = 1'b0;
    cycle();

    // Single request: two bytes, then release once the UART is idle.
    sent.delete();
    pedido = 4'b0001;
    cycle();
    check("single_grant_latency", habilitar_envio, 4'b0001);
    fonte_iniciar_envio = 4'b0001; fonte_dado_saida[7:0] = 8'hAE; cycle();
    fonte_iniciar_envio = 4'b0000; cycle();
    fonte_iniciar_envio = 4'b0001; fonte_dado_saida[7:0] = 8'h85; cycle();
    fonte_iniciar_envio = 4'b0000; fonte_envio_concluido = 4'b0001; cycle();
    fonte_envio_concluido = 4'b0000; pedido = 4'b0000; uart_ocupado = 1'b1;
    cycle(); cycle();
    check("single_holds_finaliza", ocupado, 1'b1);
    uart_ocupado = 1'b0; cycle();
    check("single_back_idle", ocupado, 1'b0);
    check("single_byte_count", sent.size(), 2);
    check("single_byte0", sent[0], 8'hAE);
    check("single_byte1", sent[1], 8'h85);

    // Fairness with all four requesting continuously.
    do_reset();
    grants.delete();
    pedido = 4'b1111;
    guard = 0;
    while (grants.size() < 5 && guard < 200) begin
      fonte_envio_concluido = (m_phase == 1 && m_done >= 1) ? (N'(1) << m_g) : '0;
      cycle();
      guard++;
    end
    check("fair_grant_count", grants.size(), 5);
    check("fair_order0", grants[0], 0);
    check("fair_order1", grants[1], 1);
    check("fair_order2", grants[2], 2);
    check("fair_order3", grants[3], 3);
    check("fair_order4", grants[4], 0);

    // Isolation: source 1 strobes while source 0 holds the grant.
    do_reset();
    pedido = 4'b0011;
    cycle();
    for (int i = 0; i < 8; i++) begin
      fonte_iniciar_envio = {2'b00, 1'(i % 2), 1'(i % 3 == 0)};
      fonte_dado_saida = {8'h44, 8'h33, 8'h22 + 8'(i), 8'h11 + 8'(i)};
      cycle();
      check("isolation_iniciar", uart_iniciar_envio, fonte_iniciar_envio[0]);
      check("isolation_dado", uart_dado, fonte_dado_saida[7:0]);
    end
    fonte_iniciar_envio = '0; fonte_envio_concluido = 4'b0001; cycle();
    clear_inputs(); cycle(); cycle();

    // Timeout: source 2 never concludes.
    do_reset();
    err_seen = 0;
    pedido = 4'b0100;
    cycle();
    t_grant = cyc;
    check("timeout_granted_2", habilitar_envio, 4'b0100);
    guard = 0;
    while (err_seen == 0 && guard < 40) begin cycle(); guard++; end
    check("timeout_distance", err_edge - t_grant, TMO);
    pedido = 4'b1111;
    grants.delete();
    guard = 0;
    while (grants.size() == 0 && guard < 20) begin cycle(); guard++; end
    check("timeout_next_grant", grants[0], 3);
    check("timeout_single_pulse", err_seen, 1);
    clear_inputs(); fonte_envio_concluido = 4'b1000; cycle();
    clear_inputs(); cycle(); cycle();

    // Conclusion on the very cycle the watchdog expires.
    do_reset();
    err_seen = 0;
    pedido = 4'b0001;
    cycle();
    guard = 0;
    while (m_phase == 1 && m_done < TMO - 1 && guard < 40) begin cycle(); guard++; end
    check("coincide_reached", m_done, TMO - 1);
    fonte_envio_concluido = 4'b0001; cycle();
    check("coincide_finaliza", habilitar_envio, 4'b0000);
    clear_inputs(); cycle(); cycle();
    check("coincide_no_error", err_seen, 0);

    // Abort by dropping the request mid-grant.
    do_reset();
    err_seen = 0;
    pedido = 4'b0010;
    cycle(); cycle(); cycle();
    pedido = 4'b0000; cycle();
    check("abort_hab_cleared", habilitar_envio, 4'b0000);
    check("abort_in_finaliza", ocupado, 1'b1);
    cycle(); cycle();
    check("abort_no_error", err_seen, 0);

    // Asynchronous reset in the middle of a grant.
    pedido = 4'b0001;
    cycle(); cycle(); cycle();
    check("midreset_granted", habilitar_envio, 4'b0001);
    @(negedge clock); #2;
    reset = 1'b1;
    #1;
    check_reset_values("midreset");
    model_reset();
    prev_hab = '0;
    clear_inputs();
    @(posedge clock); #1;
    reset = 1'b0;
    pedido = 4'b0100;
    cycle();
    check("post_reset_grant", habilitar_envio, 4'b0100);
    fonte_envio_concluido = 4'b0100; cycle();
    clear_inputs(); cycle(); cycle();

    // Randomized traffic from four well-behaved senders.
    do_reset();
    pend = '0;
    for (int it = 0; it < 3000; it++) begin
      for (int i = 0; i < N; i++)
        if (!bitof(pend, i) && $urandom_range(0, 7) == 0) pend = pend | (N'(1) << i);
      fonte_iniciar_envio = N'($urandom);
      fonte_dado_saida = 32'($urandom);
      fonte_envio_concluido = ($urandom_range(0, 9) == 0) ? N'($urandom) : '0;
      was_g = -1;
      if (m_phase == 1) begin
        was_g = m_g;
        fonte_envio_concluido = fonte_envio_concluido & ~(N'(1) << m_g);
        if ($urandom_range(0, 7) == 0) fonte_envio_concluido = fonte_envio_concluido | (N'(1) << m_g);
        if ($urandom_range(0, 49) == 0) pend = pend & ~(N'(1) << m_g);
      end
      pedido = pend;
      uart_ocupado = ($urandom_range(0, 2) == 0);
      cycle();
      if (was_g >= 0 && bitof(fonte_envio_concluido, was_g)) pend = pend & ~(N'(1) << was_g);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_event_arbiter.md
TX_EVENT_ARBITER -- requirements
Module: tx_event_arbiter

Interface
REQ-001 Parameter NUM_FONTES, default 4: number of event senders sharing one UART transmitter (2..8).
REQ-002 Parameter TIMEOUT_CICLOS, default 100000: maximum grant length in clock cycles before a forced abort.
REQ-003 Port clock  input  1: single clock; all state changes on its rising edge.
REQ-004 Port reset  input  1: asynchronous, active-high reset.
REQ-005 Port pedido  input  NUM_FONTES: per-source level request; held high until that source's envio_concluido.
REQ-006 Port habilitar_envio  output  NUM_FONTES: one-hot registered grant, driving each sender's habilitar_envio.
REQ-007 Port fonte_iniciar_envio  input  NUM_FONTES: per-source iniciar_envio.
REQ-008 Port fonte_dado_saida  input  8*NUM_FONTES: per-source dado_saida; source i occupies bits [8i+7:8i].
REQ-009 Port fonte_envio_concluido  input  NUM_FONTES: per-source envio_concluido.
REQ-010 Port uart_ocupado  input  1: UART transmitter busy; also fanned out unchanged to every sender.
REQ-011 Port uart_iniciar_envio  output  1: start strobe to the UART.
REQ-012 Port uart_dado  output  8: byte to the UART.
REQ-013 Port fonte_atual  output  clog2(NUM_FONTES): index of the granted or last-granted source.
REQ-014 Port ocupado  output  1: high in any state except OCIOSO.
REQ-015 Port erro_timeout  output  1: one-cycle pulse on a timeout abort.

Function
REQ-016 The FSM SHALL have three states: OCIOSO, CONCEDIDO and FINALIZA.
REQ-017 OCIOSO with pedido != 0 -> CONCEDIDO next cycle; habilitar_envio SHALL become one-hot for the winner (latency 1 cycle).
REQ-018 Winner SHALL be chosen round-robin: first set pedido bit searching upward from (ultimo+1) mod NUM_FONTES, where ultimo is the last granted index (reset value NUM_FONTES-1, so source 0 wins first).
REQ-019 In CONCEDIDO, uart_iniciar_envio and uart_dado SHALL combinationally follow fonte_iniciar_envio[g] and fonte_dado_saida[g] for granted index g.
REQ-020 Outside CONCEDIDO, uart_iniciar_envio SHALL be 0 and uart_dado SHALL be 8'h00; iniciar strobes from non-granted sources SHALL be ignored.
REQ-021 CONCEDIDO -> FINALIZA on fonte_envio_concluido[g]=1; habilitar_envio SHALL be all-zero from the next cycle.
REQ-022 CONCEDIDO -> FINALIZA if pedido[g] falls before concluido (abort); erro_timeout SHALL stay 0.
REQ-023 A watchdog counter, width clog2(TIMEOUT_CICLOS+1), SHALL clear on entry to CONCEDIDO and increment each CONCEDIDO cycle.
REQ-024 When the watchdog reaches TIMEOUT_CICLOS, the FSM SHALL go CONCEDIDO -> FINALIZA and pulse erro_timeout for exactly 1 cycle.
REQ-025 If concluido and timeout coincide, concluido SHALL win: no erro_timeout.
REQ-026 FINALIZA -> OCIOSO on the first cycle with uart_ocupado=0; ultimo SHALL update to g on that transition.
REQ-027 At least one OCIOSO cycle SHALL separate consecutive grants, giving senders a clean habilitar_envio falling edge.
REQ-028 Requests arriving during CONCEDIDO or FINALIZA SHALL be held pending, not dropped.
REQ-029 fonte_atual SHALL update on grant and hold its value through OCIOSO.

Reset
REQ-030 Reset SHALL force: state OCIOSO, habilitar_envio 0, watchdog 0, ultimo NUM_FONTES-1, fonte_atual 0, erro_timeout 0, uart_iniciar_envio 0, ocupado 0.
REQ-031 Reset mid-grant SHALL drop the grant immediately (asynchronously); no erro_timeout pulse SHALL be produced.

Structure
REQ-032 A shared package comms_pkg SHALL hold the state enum (OCIOSO, CONCEDIDO, FINALIZA) and a clog2-style width helper.
REQ-033 Round-robin selection SHALL live in a combinational sub-module rr_seletor (inputs: pedido, ultimo; outputs: valido, indice).

Verification
REQ-034 Single request: pedido=0001, sender sends EVENT_CODE AE then byte 85 -> uart_dado sequence AE,85; habilitar_envio=0001 one cycle after pedido; returns to OCIOSO once uart_ocupado=0.
REQ-035 Fairness: pedido=1111 held continuously -> grant order 0,1,2,3,0; each grant followed by one OCIOSO cycle.
REQ-036 Timeout: TIMEOUT_CICLOS=16, source 2 granted and never concludes -> erro_timeout pulse exactly 16 cycles after grant; the next grant goes to source 3.
REQ-037 Isolation: source 1 toggles fonte_iniciar_envio while source 0 is granted -> uart_iniciar_envio mirrors only source 0.
REQ-038 Coincidence and abort: concluido on the same cycle as the timeout -> no erro_timeout; pedido[g] dropped mid-grant -> FINALIZA with no error pulse.
REQ-039 Reset asserted mid-CONCEDIDO -> all outputs at reset values in the same cycle; after release, pedido=0100 -> source 2 granted.
